id_stage: RTL and testbench

//  Decode stage of the 5-stage LA32R pipeline, directly downstream of IF. Latches {inst,pc}

---
 rtl/id_stage.sv | 199 +++++++++++++++++++
 tb/tb_id_stage.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// id_stage: LA32R decode stage. Holds the instruction handed over by IF, decodes a
// base integer subset, reads the register file through ES/MS/WS forwarding, resolves
// branches back to IF and stalls for one cycle on a load-use hazard.
module id_stage (
  input  logic         clk,
  input  logic         resetn,
  input  logic         es_allowin,
  output logic         ds_allowin,
  input  logic         fs_to_ds_valid,
  input  logic [63:0]  fs_to_ds_bus,
  output logic [32:0]  br_bus,
  output logic         ds_to_es_valid,
  output logic [141:0] ds_to_es_bus,
  input  logic [39:0]  es_fwd_bus,
  input  logic [38:0]  ms_fwd_bus,
  input  logic [37:0]  ws_to_rf_bus
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_LUI  = 4'd7;

  logic        ds_valid_q;
  logic [31:0] ds_inst_q;
  logic [31:0] ds_pc_q;
  logic [31:0] rf_q [32];

  logic        ws_we;
  logic [4:0]  ws_waddr;
  logic [31:0] ws_wdata;
  assign ws_we    = ws_to_rf_bus[37];
  assign ws_waddr = ws_to_rf_bus[36:32];
  assign ws_wdata = ws_to_rf_bus[31:0];

  logic [4:0] rd, rj, rk, rkd_addr;
  assign rd = ds_inst_q[4:0];
  assign rj = ds_inst_q[9:5];
  assign rk = ds_inst_q[14:10];

  // Value seen by a source register: youngest in-flight producer wins, r0 is always zero.
  function automatic logic [31:0] fwd_value(
    input logic [4:0]  addr,
    input logic [39:0] es,
    input logic [38:0] ms,
    input logic [37:0] ws,
    input logic [31:0] rf_val
  );
    logic [31:0] v;
    if (addr == 5'd0) v = 32'd0;
    else if (es[39] && es[38] && (es[37:33] == addr)) v = es[31:0];
    else if (ms[38] && ms[37] && (ms[36:32] == addr)) v = ms[31:0];
    else if (ws[37] && (ws[36:32] == addr)) v = ws[31:0];
    else v = rf_val;
    return v;
  endfunction

  // A load still in EX cannot forward its data yet.
  function automatic logic es_load_hit(input logic [4:0] addr, input logic [39:0] es);
    return es[39] && es[38] && es[32] && (es[37:33] == addr) && (addr != 5'd0);
  endfunction

  logic [3:0]  alu_op;
  logic        src1_is_pc, src2_is_imm, res_from_mem, mem_we, wr_en, is_3r;
  logic [4:0]  dest;
  logic [31:0] imm;
  logic        rj_read, rkd_read, rkd_is_rd;
  logic        is_b, is_jirl, is_beq, is_bne;

  // Instruction decode; anything unrecognised falls through as a NOP.
  always_comb begin
    alu_op       = ALU_ADD;
    src1_is_pc   = 1'b0;
    src2_is_imm  = 1'b0;
    res_from_mem = 1'b0;
    mem_we       = 1'b0;
    wr_en        = 1'b0;
    is_3r        = 1'b0;
    dest         = rd;
    imm          = 32'd0;
    rj_read      = 1'b0;
    rkd_read     = 1'b0;
    rkd_is_rd    = 1'b0;
    is_b         = 1'b0;
    is_jirl      = 1'b0;
    is_beq       = 1'b0;
    is_bne       = 1'b0;
    case (ds_inst_q[31:26])
      6'h13: begin
        is_jirl = 1'b1; rj_read = 1'b1; wr_en = 1'b1;
        src1_is_pc = 1'b1; src2_is_imm = 1'b1; imm = 32'd4;
      end
      6'h14: is_b = 1'b1;
      6'h15: begin
        is_b = 1'b1; wr_en = 1'b1; dest = 5'd1;
        src1_is_pc = 1'b1; src2_is_imm = 1'b1; imm = 32'd4;
      end
      6'h16: begin is_beq = 1'b1; rj_read = 1'b1; rkd_read = 1'b1; rkd_is_rd = 1'b1; end
      6'h17: begin is_bne = 1'b1; rj_read = 1'b1; rkd_read = 1'b1; rkd_is_rd = 1'b1; end
      default: begin
        if (ds_inst_q[31:25] == 7'h0a) begin
          alu_op = ALU_LUI; wr_en = 1'b1; src2_is_imm = 1'b1;
          imm = {ds_inst_q[24:5], 12'h000};
        end else if (ds_inst_q[31:22] == 10'h00a || ds_inst_q[31:22] == 10'h0a2) begin
          wr_en = 1'b1; rj_read = 1'b1; src2_is_imm = 1'b1;
          res_from_mem = (ds_inst_q[31:22] == 10'h0a2);
          imm = {{20{ds_inst_q[21]}}, ds_inst_q[21:10]};
        end else if (ds_inst_q[31:22] == 10'h0a6) begin
          mem_we = 1'b1; rj_read = 1'b1; rkd_read = 1'b1; rkd_is_rd = 1'b1; src2_is_imm = 1'b1;
          imm = {{20{ds_inst_q[21]}}, ds_inst_q[21:10]};
        end else begin
          case (ds_inst_q[31:15])
            17'h00020: begin alu_op = ALU_ADD;  is_3r = 1'b1; end
            17'h00022: begin alu_op = ALU_SUB;  is_3r = 1'b1; end
            17'h00024: begin alu_op = ALU_SLT;  is_3r = 1'b1; end
            17'h00025: begin alu_op = ALU_SLTU; is_3r = 1'b1; end
            17'h00029: begin alu_op = ALU_AND;  is_3r = 1'b1; end
            17'h0002a: begin alu_op = ALU_OR;   is_3r = 1'b1; end
            17'h0002b: begin alu_op = ALU_XOR;  is_3r = 1'b1; end
            default:   begin alu_op = ALU_ADD;  is_3r = 1'b0; end
          endcase
          if (is_3r) begin
            wr_en = 1'b1; rj_read = 1'b1; rkd_read = 1'b1;
          end else begin
            wr_en = 1'b0;
          end
        end
      end
    endcase
  end

  logic [31:0] rj_value, rkd_value;
  logic        rf_we, ds_ready_go;
  assign rkd_addr  = rkd_is_rd ? rd : rk;
  assign rj_value  = fwd_value(rj, es_fwd_bus, ms_fwd_bus, ws_to_rf_bus, rf_q[rj]);
  assign rkd_value = fwd_value(rkd_addr, es_fwd_bus, ms_fwd_bus, ws_to_rf_bus, rf_q[rkd_addr]);
  assign rf_we     = wr_en & (dest != 5'd0);
  assign ds_ready_go = !((rj_read && es_load_hit(rj, es_fwd_bus)) ||
                         (rkd_read && es_load_hit(rkd_addr, es_fwd_bus)));

  assign ds_allowin     = !ds_valid_q || (ds_ready_go && es_allowin);
  assign ds_to_es_valid = ds_valid_q && ds_ready_go;
  assign ds_to_es_bus   = {alu_op, src1_is_pc, src2_is_imm, res_from_mem, mem_we, rf_we,
                           dest, imm, rj_value, rkd_value, ds_pc_q};

  logic [31:0] off_b, off_16, br_target;
  logic        br_cond, br_taken;
  assign off_b  = {{4{ds_inst_q[9]}}, ds_inst_q[9:0], ds_inst_q[25:10], 2'b00};
  assign off_16 = {{14{ds_inst_q[25]}}, ds_inst_q[25:10], 2'b00};

  // Branch condition and target from the forwarded operands.
  always_comb begin
    br_cond   = 1'b0;
    br_target = 32'd0;
    if (is_b) begin
      br_cond = 1'b1; br_target = ds_pc_q + off_b;
    end else if (is_jirl) begin
      br_cond = 1'b1; br_target = rj_value + off_16;
    end else if (is_beq) begin
      br_cond = (rj_value == rkd_value); br_target = ds_pc_q + off_16;
    end else if (is_bne) begin
      br_cond = (rj_value != rkd_value); br_target = ds_pc_q + off_16;
    end else begin
      br_cond = 1'b0; br_target = 32'd0;
    end
  end

  assign br_taken = ds_valid_q && ds_ready_go && br_cond;
  assign br_bus   = {br_taken, br_taken ? br_target : 32'd0};

  // Pipeline register: accept from IF when allowed, squash the wrong-path slot after a taken branch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ds_valid_q <= 1'b0;
      ds_inst_q  <= 32'd0;
      ds_pc_q    <= 32'd0;
    end else begin
      if (ds_allowin) ds_valid_q <= fs_to_ds_valid && !br_taken;
      if (fs_to_ds_valid && ds_allowin) begin
        ds_inst_q <= fs_to_ds_bus[63:32];
        ds_pc_q   <= fs_to_ds_bus[31:0];
      end
    end
  end

  // Register file write port driven by WB; r0 is never written.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else if (ws_we && (ws_waddr != 5'd0)) begin
      rf_q[ws_waddr] <= ws_wdata;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed stimulus for id_stage, checked every cycle against an
// instruction-level model of the decode stage plus hand-computed expectations.
module tb_id_stage;

  logic         clk = 1'b0;
  logic         resetn;
  logic         es_allowin;
  logic         ds_allowin;
  logic         fs_valid;
  logic [63:0]  fs_bus;
  logic [32:0]  br_bus;
  logic         ds_to_es_valid;
  logic [141:0] ds_to_es_bus;
  logic [39:0]  es_fwd;
  logic [38:0]  ms_fwd;
  logic [37:0]  ws_bus;

  int passed = 0;
  int total  = 0;
  logic started = 1'b0;

  id_stage dut (
    .clk(clk), .resetn(resetn), .es_allowin(es_allowin), .ds_allowin(ds_allowin),
    .fs_to_ds_valid(fs_valid), .fs_to_ds_bus(fs_bus), .br_bus(br_bus),
    .ds_to_es_valid(ds_to_es_valid), .ds_to_es_bus(ds_to_es_bus),
    .es_fwd_bus(es_fwd), .ms_fwd_bus(ms_fwd), .ws_to_rf_bus(ws_bus)
  );

  always #5 clk = ~clk;

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc3r(input logic [16:0] op, input logic [4:0] rd, input logic [4:0] rj, input logic [4:0] rk);
    return {op, rk, rj, rd};
  endfunction
  function automatic logic [31:0] enc12(input logic [9:0] op, input logic [4:0] rd, input logic [4:0] rj, input logic [11:0] si);
    return {op, si, rj, rd};
  endfunction
  function automatic logic [31:0] enc_lu(input logic [4:0] rd, input logic [19:0] si);
    return {7'h0a, si, rd};
  endfunction
  function automatic logic [31:0] enc16(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rj, input logic [15:0] offs);
    return {op, offs, rj, rd};
  endfunction
  function automatic logic [31:0] enc26(input logic [5:0] op, input logic [25:0] offs);
    return {op, offs[15:0], offs[25:16]};
  endfunction

  // ---------------- behavioural model ----------------
  localparam logic [3:0] K_NOP = 4'd0, K_3R = 4'd1, K_ADDI = 4'd2, K_LD = 4'd3, K_ST = 4'd4,
                         K_LUI = 4'd5, K_JIRL = 4'd6, K_B = 4'd7, K_BL = 4'd8, K_BEQ = 4'd9, K_BNE = 4'd10;

  typedef struct packed {
    logic [3:0]  kind;
    logic [3:0]  op;
    logic        s1pc, s2imm, ldm, mwe, writes;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic        rd_j, rd_k, k_is_rd;
  } dec_t;

  typedef struct packed {
    logic         valid_out;
    logic         allowin;
    logic [32:0]  br;
    logic [141:0] bus;
  } exp_t;

  logic        m_valid;
  logic [31:0] m_inst, m_pc;
  logic [31:0] m_rf [32];

  function automatic dec_t m_decode(input logic [31:0] in);
    dec_t d;
    logic [16:0] ops3r [7];
    ops3r = '{17'h20, 17'h22, 17'h24, 17'h25, 17'h29, 17'h2a, 17'h2b};
    d = '0;
    d.dest = in[4:0];
    case (in[31:26])
      6'h13: begin d.kind = K_JIRL; d.s1pc = 1'b1; d.s2imm = 1'b1; d.writes = 1'b1; d.imm = 32'd4; d.rd_j = 1'b1; end
      6'h14: d.kind = K_B;
      6'h15: begin d.kind = K_BL; d.s1pc = 1'b1; d.s2imm = 1'b1; d.writes = 1'b1; d.imm = 32'd4; d.dest = 5'd1; end
      6'h16: begin d.kind = K_BEQ; d.rd_j = 1'b1; d.rd_k = 1'b1; d.k_is_rd = 1'b1; end
      6'h17: begin d.kind = K_BNE; d.rd_j = 1'b1; d.rd_k = 1'b1; d.k_is_rd = 1'b1; end
      default: begin
        if (in[31:25] == 7'h0a) begin
          d.kind = K_LUI; d.op = 4'd7; d.s2imm = 1'b1; d.writes = 1'b1; d.imm = {in[24:5], 12'h000};
        end else if (in[31:22] == 10'h00a || in[31:22] == 10'h0a2) begin
          d.kind = (in[31:22] == 10'h0a2) ? K_LD : K_ADDI;
          d.ldm = (in[31:22] == 10'h0a2); d.s2imm = 1'b1; d.writes = 1'b1; d.rd_j = 1'b1;
          d.imm = 32'($signed(in[21:10]));
        end else if (in[31:22] == 10'h0a6) begin
          d.kind = K_ST; d.mwe = 1'b1; d.s2imm = 1'b1; d.rd_j = 1'b1; d.rd_k = 1'b1; d.k_is_rd = 1'b1;
          d.imm = 32'($signed(in[21:10]));
        end else begin
          for (int i = 0; i < 7; i++) begin
            if (in[31:15] == ops3r[i]) begin
              d.kind = K_3R; d.op = 4'(i); d.writes = 1'b1; d.rd_j = 1'b1; d.rd_k = 1'b1;
            end
          end
        end
      end
    endcase
    return d;
  endfunction

  function automatic logic m_load_hit(input logic [4:0] a);
    return es_fwd[39] && es_fwd[38] && es_fwd[32] && es_fwd[37:33] == a && a != 5'd0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (es_fwd[39] && es_fwd[38] && es_fwd[37:33] == a) return es_fwd[31:0];
    if (ms_fwd[38] && ms_fwd[37] && ms_fwd[36:32] == a) return ms_fwd[31:0];
    if (ws_bus[37] && ws_bus[36:32] == a) return ws_bus[31:0];
    return m_rf[a];
  endfunction

  function automatic exp_t m_eval();
    exp_t e; dec_t d;
    logic [4:0] ja, ka; logic [31:0] vj, vk, tgt; logic cond, stall; int off;
    d  = m_decode(m_inst);
    ja = m_inst[9:5];
    ka = d.k_is_rd ? m_inst[4:0] : m_inst[14:10];
    vj = m_read(ja);
    vk = m_read(ka);
    stall = (d.rd_j && m_load_hit(ja)) || (d.rd_k && m_load_hit(ka));
    cond = 1'b0; tgt = 32'd0; off = 0;
    case (d.kind)
      K_B, K_BL: begin off = $signed({m_inst[9:0], m_inst[25:10]}); cond = 1'b1; tgt = m_pc + 32'(off * 4); end
      K_JIRL:    begin off = $signed(m_inst[25:10]); cond = 1'b1; tgt = vj + 32'(off * 4); end
      K_BEQ:     begin off = $signed(m_inst[25:10]); cond = (vj == vk); tgt = m_pc + 32'(off * 4); end
      K_BNE:     begin off = $signed(m_inst[25:10]); cond = (vj != vk); tgt = m_pc + 32'(off * 4); end
      default:   cond = 1'b0;
    endcase
    e.valid_out = m_valid && !stall;
    e.allowin   = !m_valid || (!stall && es_allowin);
    e.br        = (m_valid && !stall && cond) ? {1'b1, tgt} : 33'd0;
    e.bus       = {d.op, d.s1pc, d.s2imm, d.ldm, d.mwe, d.writes && d.dest != 5'd0,
                   d.dest, d.imm, vj, vk, m_pc};
    return e;
  endfunction

  // Model state advances on the same edge as the DUT, from the same inputs.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_valid <= 1'b0; m_inst <= 32'd0; m_pc <= 32'd0;
      for (int i = 0; i < 32; i++) m_rf[i] <= 32'd0;
    end else begin : upd
      exp_t e;
      e = m_eval();
      if (e.allowin) m_valid <= fs_valid && !e.br[32];
      if (fs_valid && e.allowin) begin m_inst <= fs_bus[63:32]; m_pc <= fs_bus[31:0]; end
      if (ws_bus[37] && ws_bus[36:32] != 5'd0) m_rf[ws_bus[36:32]] <= ws_bus[31:0];
    end
  end

  task automatic check(input string nm, input logic [141:0] act, input logic [141:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (started) begin : cmp
      exp_t e;
      e = m_eval();
      check("model_allowin", 142'(ds_allowin), 142'(e.allowin));
      check("model_es_valid", 142'(ds_to_es_valid), 142'(e.valid_out));
      check("model_br_bus", 142'(br_bus), 142'(e.br));
      if (e.valid_out) check("model_bus", ds_to_es_bus, e.bus);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] inst, input logic [31:0] pc);
    fs_valid = 1'b1;
    fs_bus   = {inst, pc};
  endtask

  logic [31:0] tbl [18];

  initial begin
    resetn = 1'b1; es_allowin = 1'b1; fs_valid = 1'b0; fs_bus = 64'd0;
    es_fwd = 40'd0; ms_fwd = 39'd0; ws_bus = 38'd0;
    #2 resetn = 1'b0; started = 1'b1;
    tick(); tick();
    check("rst_allowin", 142'(ds_allowin), 142'(1'b1));
    check("rst_es_valid", 142'(ds_to_es_valid), 142'(1'b0));
    check("rst_br_bus", 142'(br_bus), 142'(33'd0));
    resetn = 1'b1;

    // 1: regfile read of values written by WB
    ws_bus = {1'b1, 5'd1, 32'd5}; tick();
    ws_bus = {1'b1, 5'd2, 32'd7}; tick();
    ws_bus = 38'd0; feed(enc3r(17'h20, 5'd3, 5'd1, 5'd2), 32'h1C000000); tick();
    fs_valid = 1'b0; #1;
    check("t1_valid", 142'(ds_to_es_valid), 142'(1'b1));
    check("t1_alu_op", 142'(ds_to_es_bus[141:138]), 142'(4'd0));
    check("t1_rj", 142'(ds_to_es_bus[95:64]), 142'(32'd5));
    check("t1_rkd", 142'(ds_to_es_bus[63:32]), 142'(32'd7));
    check("t1_dest", 142'(ds_to_es_bus[132:128]), 142'(5'd3));
    check("t1_rf_we", 142'(ds_to_es_bus[133]), 142'(1'b1));
    tick();

    // 2: forwarding priority ES > MS > WS
    feed(enc12(10'h00a, 5'd5, 5'd4, 12'd1), 32'h1C000004); tick();
    fs_valid = 1'b0; es_allowin = 1'b0;
    es_fwd = {1'b1, 1'b1, 5'd4, 1'b0, 32'hAA}; #1;
    check("t2_es_fwd", 142'(ds_to_es_bus[95:64]), 142'(32'hAA));
    check("t2_imm", 142'(ds_to_es_bus[127:96]), 142'(32'd1));
    ms_fwd = {1'b1, 1'b1, 5'd4, 32'h55}; #1;
    check("t2_es_over_ms", 142'(ds_to_es_bus[95:64]), 142'(32'hAA));
    tick();
    es_fwd = 40'd0; #1;
    check("t2_ms_fwd", 142'(ds_to_es_bus[95:64]), 142'(32'h55));
    tick();
    ms_fwd = 39'd0; ws_bus = {1'b1, 5'd4, 32'h33}; es_allowin = 1'b1; #1;
    check("t2_ws_fwd", 142'(ds_to_es_bus[95:64]), 142'(32'h33));
    tick();
    ws_bus = 38'd0;

    // 3: load-use bubble, then MS supplies the loaded value
    feed(enc3r(17'h20, 5'd7, 5'd6, 5'd0), 32'h1C000008); tick();
    feed(enc12(10'h00a, 5'd8, 5'd0, 12'd3), 32'h1C00000C);
    es_fwd = {1'b1, 1'b1, 5'd6, 1'b1, 32'hDEAD}; #1;
    check("t3_stall_valid", 142'(ds_to_es_valid), 142'(1'b0));
    check("t3_stall_allowin", 142'(ds_allowin), 142'(1'b0));
    tick();
    es_fwd = 40'd0; ms_fwd = {1'b1, 1'b1, 5'd6, 32'h1234}; #1;
    check("t3_issue_valid", 142'(ds_to_es_valid), 142'(1'b1));
    check("t3_issue_rj", 142'(ds_to_es_bus[95:64]), 142'(32'h1234));
    check("t3_held_pc", 142'(ds_to_es_bus[31:0]), 142'(32'h1C000008));
    tick();
    fs_valid = 1'b0; ms_fwd = 39'd0; #1;
    check("t3_next_pc", 142'(ds_to_es_bus[31:0]), 142'(32'h1C00000C));
    check("t3_next_imm", 142'(ds_to_es_bus[127:96]), 142'(32'd3));
    tick();

    // 4: taken beq redirects and drops the wrong-path instruction
    feed(enc16(6'h16, 5'd1, 5'd1, 16'd4), 32'h1C000000); tick();
    feed(enc3r(17'h20, 5'd3, 5'd1, 5'd2), 32'h1C000004); #1;
    check("t4_br_bus", 142'(br_bus), 142'({1'b1, 32'h1C000010}));
    tick();
    fs_valid = 1'b0; #1;
    check("t4_dropped", 142'(ds_to_es_valid), 142'(1'b0));
    tick();

    // 5: untaken bne, then an invalid opcode decodes as a NOP
    feed(enc16(6'h17, 5'd1, 5'd1, 16'd4), 32'h1C000010); tick();
    feed(32'hFFFFFFFF, 32'h1C000014); #1;
    check("t5_not_taken", 142'(br_bus), 142'(33'd0));
    check("t5_allowin", 142'(ds_allowin), 142'(1'b1));
    tick();
    fs_valid = 1'b0; #1;
    check("t5_nop_valid", 142'(ds_to_es_valid), 142'(1'b1));
    check("t5_nop_pc", 142'(ds_to_es_bus[31:0]), 142'(32'h1C000014));
    check("t5_nop_rf_we", 142'(ds_to_es_bus[133]), 142'(1'b0));
    check("t5_nop_mem_we", 142'(ds_to_es_bus[134]), 142'(1'b0));
    tick();

    // Mixed stream through the model; each taken branch is followed by a filler that must drop.
    tbl = '{enc3r(17'h22, 5'd8, 5'd2, 5'd1), enc3r(17'h24, 5'd9, 5'd1, 5'd2),
            enc3r(17'h25, 5'd10, 5'd2, 5'd1), enc3r(17'h29, 5'd11, 5'd1, 5'd2),
            enc3r(17'h2a, 5'd12, 5'd1, 5'd2), enc3r(17'h2b, 5'd13, 5'd1, 5'd2),
            enc_lu(5'd14, 20'h12345), enc12(10'h0a6, 5'd2, 5'd1, 12'd8),
            enc12(10'h0a2, 5'd15, 5'd1, 12'hFFC), enc26(6'h15, 26'h40),
            enc3r(17'h20, 5'd20, 5'd1, 5'd2), enc16(6'h13, 5'd16, 5'd1, 16'h10),
            enc3r(17'h20, 5'd20, 5'd1, 5'd2), enc26(6'h14, 26'h3FFFFFE),
            enc3r(17'h20, 5'd20, 5'd1, 5'd2), enc16(6'h17, 5'd2, 5'd1, 16'd2),
            enc3r(17'h20, 5'd20, 5'd1, 5'd2), enc12(10'h00a, 5'd0, 5'd1, 12'd1)};
    for (int i = 0; i < 18; i++) begin
      feed(tbl[i], 32'h1C000100 + 32'(4 * i));
      if (i == 3) begin
        es_allowin = 1'b0; tick(); es_allowin = 1'b1;
      end
      tick();
      if (i == 13) check("b_target", 142'(br_bus), 142'({1'b1, 32'h1C00012C}));
    end
    fs_valid = 1'b0; tick(); tick();

    // 6: asynchronous reset while a branch is stalled on a load
    feed(enc16(6'h16, 5'd6, 5'd1, 16'd4), 32'h1C000200); tick();
    fs_valid = 1'b0; es_fwd = {1'b1, 1'b1, 5'd6, 1'b1, 32'hBEEF}; #1;
    check("t6_stall_valid", 142'(ds_to_es_valid), 142'(1'b0));
    check("t6_stall_br", 142'(br_bus), 142'(33'd0));
    resetn = 1'b0; #1;
    check("t6_rst_valid", 142'(ds_to_es_valid), 142'(1'b0));
    check("t6_rst_br", 142'(br_bus), 142'(33'd0));
    check("t6_rst_allowin", 142'(ds_allowin), 142'(1'b1));
    tick();
    resetn = 1'b1; es_fwd = 40'd0;
    feed(enc3r(17'h20, 5'd3, 5'd1, 5'd2), 32'h1C000300); tick();
    fs_valid = 1'b0; #1;
    check("t6_post_valid", 142'(ds_to_es_valid), 142'(1'b1));
    check("t6_post_rj", 142'(ds_to_es_bus[95:64]), 142'(32'd0));
    check("t6_post_rkd", 142'(ds_to_es_bus[63:32]), 142'(32'd0));
    tick(); tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
